// File: rtl/pe_row_16.sv
// rtl/pe_row_16.sv - 16-PE multiply-accumulate row: sliding-window dot product of the last 16 (r,f) pairs.
// Define PE_ROW_SAT_EN to saturate o_psum; the default build wraps it modulo 2**(2*WIDTH).
module pe_row_16 #(
  parameter int WIDTH = 8,
  parameter int NPE   = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic [WIDTH-1:0]   i_r,
  input  logic [WIDTH-1:0]   i_f,
  output logic [2*WIDTH-1:0] o_psum
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = PW + 4;

  logic [WIDTH-1:0] r_q [NPE];
  logic [WIDTH-1:0] f_q [NPE];
  logic [PW-1:0]    prod [NPE];
  logic [SW-1:0]    sum_wide;
  logic [PW-1:0]    psum_next;

  // Operands are zero-extended so each product keeps its full 2*WIDTH bits.
  always_comb begin
    sum_wide = '0;
    for (int k = 0; k < NPE; k++) begin
      prod[k]  = {{WIDTH{1'b0}}, r_q[k]} * {{WIDTH{1'b0}}, f_q[k]};
      sum_wide = sum_wide + {4'b0000, prod[k]};
    end
  end

`ifdef PE_ROW_SAT_EN
  always_comb begin
    psum_next = sum_wide[PW-1:0];
    if (sum_wide[SW-1:PW] != '0) psum_next = '1;
  end
`else
  always_comb begin
    psum_next = sum_wide[PW-1:0];
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NPE; k++) begin
        r_q[k] <= '0;
        f_q[k] <= '0;
      end
      o_psum <= '0;
    end else if (en) begin
      r_q[0] <= i_r;
      f_q[0] <= i_f;
      for (int k = 1; k < NPE; k++) begin
        r_q[k] <= r_q[k-1];
        f_q[k] <= f_q[k-1];
      end
      o_psum <= psum_next;
    end
  end

endmodule

// File: tb/tb_pe_row_16.sv
// tb/tb_pe_row_16.sv - directed self-checking bench for pe_row_16.
// Expected values follow the PE_ROW_SAT_EN setting of the build.
module tb_pe_row_16;

  logic        clk;
  logic        rstn;
  logic        en;
  logic [7:0]  i_r;
  logic [7:0]  i_f;
  logic [15:0] o_psum;

  int n_checks;
  int n_fail;

  pe_row_16 #(.WIDTH(8), .NPE(16)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .en     (en),
    .i_r    (i_r),
    .i_f    (i_f),
    .o_psum (o_psum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic cycle(input logic [7:0] r, input logic [7:0] f, input logic e);
    i_r = r;
    i_f = f;
    en  = e;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_row();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
  endtask

  // Stream of the basic-window scenario: (1,1),(2,2),(3,3), r=4..16 f=0, then zeros.
  function automatic logic [7:0] samp_r(input int j);
    return (j >= 1 && j <= 16) ? 8'(j) : 8'd0;
  endfunction

  function automatic logic [7:0] samp_f(input int j);
    return (j >= 1 && j <= 3) ? 8'(j) : 8'd0;
  endfunction

  // Hand-computed o_psum after the n-th enabled edge of that stream.
  function automatic logic [15:0] exp_basic(input int n);
    if (n == 2) return 16'd1;
    if (n == 3) return 16'd5;
    if (n >= 4 && n <= 17) return 16'd14;
    if (n == 18) return 16'd13;
    if (n == 19) return 16'd9;
    return 16'd0;
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 1'b1);
      n_checks++;
      if (o_psum !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got %0d expected 0", i, o_psum);
      end
    end
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(8'd0, 8'd0, 1'b1);
      n_checks++;
      if (o_psum !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_release cycle %0d: got %0d expected 0", i, o_psum);
      end
    end
  endtask

  task automatic test_basic_window();
    clear_row();
    for (int n = 1; n <= 22; n++) begin
      cycle(samp_r(n), samp_f(n), 1'b1);
      n_checks++;
      if (o_psum !== exp_basic(n)) begin
        n_fail++;
        $display("FAIL basic_window edge %0d: got %0d expected %0d", n, o_psum, exp_basic(n));
      end
    end
  endtask

  task automatic test_enable_freeze();
    int n;
    clear_row();
    n = 0;
    for (int k = 0; k < 22 + 5; k++) begin
      if (n == 3 && k < 8) begin
        cycle(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 1'b0);
        n_checks++;
        if (o_psum !== 16'd5) begin
          n_fail++;
          $display("FAIL enable_freeze hold %0d: got %0d expected 5", k, o_psum);
        end
      end else begin
        n++;
        cycle(samp_r(n), samp_f(n), 1'b1);
        n_checks++;
        if (o_psum !== exp_basic(n)) begin
          n_fail++;
          $display("FAIL enable_freeze edge %0d: got %0d expected %0d", n, o_psum, exp_basic(n));
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] e2, e3, e17, e18;
    e2 = 16'd65025;
`ifdef PE_ROW_SAT_EN
    e3 = 16'd65535; e17 = 16'd65535; e18 = 16'd65535;
`else
    e3 = 16'd64514; e17 = 16'd57360; e18 = 16'd57871;
`endif
    clear_row();
    for (int n = 1; n <= 18; n++) begin
      if (n <= 16) cycle(8'd255, 8'd255, 1'b1);
      else cycle(8'd0, 8'd0, 1'b1);
      if (n == 2 || n == 3 || n == 17 || n == 18) begin
        logic [15:0] exp_v;
        exp_v = (n == 2) ? e2 : (n == 3) ? e3 : (n == 17) ? e17 : e18;
        n_checks++;
        if (o_psum !== exp_v) begin
          n_fail++;
          $display("FAIL overflow edge %0d: got %0d expected %0d", n, o_psum, exp_v);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    clear_row();
    for (int n = 1; n <= 5; n++) cycle(samp_r(n), samp_f(n), 1'b1);
    n_checks++;
    if (o_psum !== 16'd14) begin
      n_fail++;
      $display("FAIL async_pre got %0d expected 14", o_psum);
    end
    #1;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (o_psum !== 16'd0) begin
      n_fail++;
      $display("FAIL async_immediate got %0d expected 0", o_psum);
    end
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 18; i++) begin
      cycle(8'd0, 8'd0, 1'b1);
      n_checks++;
      if (o_psum !== 16'd0) begin
        n_fail++;
        $display("FAIL async_after cycle %0d: got %0d expected 0", i, o_psum);
      end
    end
  endtask

  task automatic test_single_pulse();
    logic [15:0] exp_v;
    clear_row();
    for (int n = 1; n <= 20; n++) begin
      if (n == 1) cycle(8'd7, 8'd9, 1'b1);
      else cycle(8'd0, 8'd0, 1'b1);
      exp_v = (n >= 2 && n <= 17) ? 16'd63 : 16'd0;
      n_checks++;
      if (o_psum !== exp_v) begin
        n_fail++;
        $display("FAIL single_pulse edge %0d: got %0d expected %0d", n, o_psum, exp_v);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn = 1'b0;
    en   = 1'b0;
    i_r  = '0;
    i_f  = '0;
    #1;
    test_reset();
    test_basic_window();
    test_enable_freeze();
    test_overflow();
    test_async_reset();
    test_single_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
